uniform_pair_gen: RTL and testbench
===================================

Name: uniform_pair_gen

Overview:
- Upstream source stage for the Box-Muller distribution block.
- Produces pairs of IEEE-754 double-precision uniform variates U1, U2 in the open interval (0,1), with a push strobe, in the same pushin/pushout style the distribution block consumes.
- Two independent xorshift64 generators feed a 3-stage pipeline: capture, leading-one detect, normalize/pack.
- Fully pipelined: accepts one request per cycle, no backpressure.

Parameters:
- SEED1, 64'h0000_0000_0000_0001, reset state of generator 1
- SEED2, 64'h9E37_79B9_7F4A_7C15, reset state of generator 2
- ZSUB, 64'h9E37_79B9_7F4A_7C15, substitute loaded when a zero seed is presented

Ports:
- clk  in  1  clock, rising-edge
- rst  in  1  reset, asynchronous, active-low
- pushin  in  1  request one (U1,U2) pair
- seed_load  in  1  load seeds this cycle
- seed1  in  64  new state, generator 1
- seed2  in  64  new state, generator 2
- pushout  out  1  U1/U2 valid this cycle
- U1  out  64  double, uniform (0,1), generator 1
- U2  out  64  double, uniform (0,1), generator 2

Behaviour:
- Reset (rst=0, async):
  - gen1 = SEED1, gen2 = SEED2.
  - All pipeline valid bits 0; pushout = 0; U1 = U2 = 0.
  - Reset mid-operation discards all in-flight pairs.
- Generator step (per generator, 64-bit): x ^= x<<13; x ^= x>>7; x ^= x<<17. Each step uses the result of the previous one.
- Stage 1, on a cycle with pushin=1 and seed_load=0:
  - Both generators step.
  - r = (stepped x)>>11 (53 bits); if r==0, r=1 (guarantees nonzero, keeps ln finite downstream).
  - r and a valid bit are registered.
- seed_load=1:
  - Load gen1 = seed1 and gen2 = seed2; a zero seed is replaced by ZSUB.
  - A simultaneous pushin is dropped: no step, no pair produced.
  - Pairs already in flight complete unaffected.
- pushin=0: state holds, a bubble propagates.
- Stage 2: p = bit index of the leading one of r (0..52). r and p are registered.
- Stage 3, pack:
  - sign = 0
  - exponent = 970 + p (11 bits, range 970..1022)
  - mantissa = (r with the leading one cleared) << (52 - p)
  - Value is exactly r * 2^-53; always < 1 and > 0; never denormal, Inf or NaN.
- Outputs are registered: pushout = stage-3 valid. U1/U2 update only when pushout=1 and hold the last value otherwise.
- Latency: pushin at edge N -> pushout=1 after edge N+3. Throughput is 1 pair/cycle, and back-to-back requests produce back-to-back pushouts in order.
- No other reordering or stalling; ordering is strictly FIFO.

Test Plan:
- Reset release, seed_load with seed1=seed2=1, then one pushin: gen state becomes 64'h40822041, r=0x81044 -> U1=U2=64'h3DD0208800000000, pushout=1 exactly 3 cycles after pushin; pushout=0 on all other cycles.
- Packing boundaries, via state chosen so r=1, r=2^52, r=2^53-1 -> U=64'h3CA0000000000000, 64'h3FE0000000000000, 64'h3FEFFFFFFFFFFFFF respectively.
- Zero-r substitution: choose a state whose stepped value has top 53 bits zero -> U=64'h3CA0000000000000, never 0.
- seed_load with seed1=0 -> gen1 loads ZSUB; the next pushin U1 matches the model stepped from ZSUB. seed_load and pushin in the same cycle -> no pushout 3 cycles later.
- 1000 back-to-back pushins, random gaps -> pushout count equals pushin count; sequence matches the C reference model; every U1/U2 has sign 0 and exponent in 970..1022.
- rst asserted with 2 pairs in flight -> pushout=0 and U1=U2=0 immediately (asynchronous); after release the first pushin yields values generated from SEED1/SEED2.

Source files
------------

// File: rtl/uniform_pair_gen.sv
`default_nettype none
// ============================================================================
//  Module      : uniform_pair_gen
//  Description : Two xorshift64 generators feeding a 3-stage pipeline
//                (capture, leading-one detect, normalize/pack) that emits
//                pairs of IEEE-754 doubles uniform on the open interval (0,1).
//  Revision    : 1.0  initial release
// ============================================================================
module uniform_pair_gen #(
    parameter logic [63:0] SEED1 = 64'h0000_0000_0000_0001,
    parameter logic [63:0] SEED2 = 64'h9E37_79B9_7F4A_7C15,
    parameter logic [63:0] ZSUB  = 64'h9E37_79B9_7F4A_7C15
) (
    input  logic        clk,
    input  logic        rst,        // asynchronous, active-low
    input  logic        pushin,
    input  logic        seed_load,
    input  logic [63:0] seed1,
    input  logic [63:0] seed2,
    output logic        pushout,
    output logic [63:0] U1,
    output logic [63:0] U2
);

    // Exponent of a value whose leading one sits at bit 0 of r (r * 2^-53).
    localparam logic [10:0] c_exp_base = 11'd970;
    localparam logic [5:0]  c_top_bit  = 6'd52;

    // One xorshift64 step; each shift uses the result of the previous one.
    function automatic logic [63:0] xs_step(input logic [63:0] x);
        logic [63:0] t;
        t = x ^ (x << 13);
        t = t ^ (t >> 7);
        t = t ^ (t << 17);
        return t;
    endfunction

    // Top 53 bits of the stepped state, forced nonzero so ln() downstream stays finite.
    function automatic logic [52:0] to_r(input logic [63:0] x);
        logic [52:0] r;
        r = 53'(x >> 11);
        if (r == 53'd0) begin
            r = 53'd1;
        end
        return r;
    endfunction

    // Bit index of the most significant one (r is never zero here).
    function automatic logic [5:0] lod(input logic [52:0] r);
        logic [5:0] p;
        p = 6'd0;
        for (int i = 0; i < 53; i++) begin
            if (r[i]) begin
                p = 6'(i);
            end
        end
        return p;
    endfunction

    // Normalize: shifting the leading one up to bit 52 and truncating to 52
    // bits drops the hidden bit and leaves the fraction field.
    function automatic logic [63:0] pack(input logic [52:0] r, input logic [5:0] p);
        logic [10:0] e;
        logic [51:0] m;
        e = c_exp_base + {5'd0, p};
        m = 52'(r << (c_top_bit - p));
        return {1'b0, e, m};
    endfunction

    // Generator state
    logic [63:0] r_gen1_q, w_gen1_d;
    logic [63:0] r_gen2_q, w_gen2_d;
    logic [63:0] w_step1, w_step2;

    // Stage 1: captured 53-bit integers
    logic        r_s1_v_q,  w_s1_v_d;
    logic [52:0] r_s1_ra_q, w_s1_ra_d;
    logic [52:0] r_s1_rb_q, w_s1_rb_d;

    // Stage 2: integers plus leading-one positions
    logic        r_s2_v_q,  w_s2_v_d;
    logic [52:0] r_s2_ra_q, w_s2_ra_d;
    logic [52:0] r_s2_rb_q, w_s2_rb_d;
    logic [5:0]  r_s2_pa_q, w_s2_pa_d;
    logic [5:0]  r_s2_pb_q, w_s2_pb_d;

    // Stage 3: registered outputs
    logic        r_pushout_q, w_pushout_d;
    logic [63:0] r_u1_q,      w_u1_d;
    logic [63:0] r_u2_q,      w_u2_d;

    // Generator update and stage-1 capture; a seed load wins over a request.
    always_comb begin
        w_step1   = xs_step(r_gen1_q);
        w_step2   = xs_step(r_gen2_q);
        w_gen1_d  = r_gen1_q;
        w_gen2_d  = r_gen2_q;
        w_s1_v_d  = 1'b0;
        w_s1_ra_d = r_s1_ra_q;
        w_s1_rb_d = r_s1_rb_q;
        if (seed_load) begin
            w_gen1_d = (seed1 == 64'd0) ? ZSUB : seed1;
            w_gen2_d = (seed2 == 64'd0) ? ZSUB : seed2;
        end else if (pushin) begin
            w_gen1_d  = w_step1;
            w_gen2_d  = w_step2;
            w_s1_v_d  = 1'b1;
            w_s1_ra_d = to_r(w_step1);
            w_s1_rb_d = to_r(w_step2);
        end
    end

    // Stage 2: locate the leading one of each integer.
    always_comb begin
        w_s2_v_d  = r_s1_v_q;
        w_s2_ra_d = r_s2_ra_q;
        w_s2_rb_d = r_s2_rb_q;
        w_s2_pa_d = r_s2_pa_q;
        w_s2_pb_d = r_s2_pb_q;
        if (r_s1_v_q) begin
            w_s2_ra_d = r_s1_ra_q;
            w_s2_rb_d = r_s1_rb_q;
            w_s2_pa_d = lod(r_s1_ra_q);
            w_s2_pb_d = lod(r_s1_rb_q);
        end
    end

    // Stage 3: pack into doubles; outputs hold their last value on bubbles.
    always_comb begin
        w_pushout_d = r_s2_v_q;
        w_u1_d      = r_u1_q;
        w_u2_d      = r_u2_q;
        if (r_s2_v_q) begin
            w_u1_d = pack(r_s2_ra_q, r_s2_pa_q);
            w_u2_d = pack(r_s2_rb_q, r_s2_pb_q);
        end
    end

    // All state registers; reset discards every in-flight pair.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gen1_q    <= SEED1;
            r_gen2_q    <= SEED2;
            r_s1_v_q    <= 1'b0;
            r_s1_ra_q   <= 53'd0;
            r_s1_rb_q   <= 53'd0;
            r_s2_v_q    <= 1'b0;
            r_s2_ra_q   <= 53'd0;
            r_s2_rb_q   <= 53'd0;
            r_s2_pa_q   <= 6'd0;
            r_s2_pb_q   <= 6'd0;
            r_pushout_q <= 1'b0;
            r_u1_q      <= 64'd0;
            r_u2_q      <= 64'd0;
        end else begin
            r_gen1_q    <= w_gen1_d;
            r_gen2_q    <= w_gen2_d;
            r_s1_v_q    <= w_s1_v_d;
            r_s1_ra_q   <= w_s1_ra_d;
            r_s1_rb_q   <= w_s1_rb_d;
            r_s2_v_q    <= w_s2_v_d;
            r_s2_ra_q   <= w_s2_ra_d;
            r_s2_rb_q   <= w_s2_rb_d;
            r_s2_pa_q   <= w_s2_pa_d;
            r_s2_pb_q   <= w_s2_pb_d;
            r_pushout_q <= w_pushout_d;
            r_u1_q      <= w_u1_d;
            r_u2_q      <= w_u2_d;
        end
    end

    assign pushout = r_pushout_q;
    assign U1      = r_u1_q;
    assign U2      = r_u2_q;

endmodule
`default_nettype wire

// File: tb/tb_uniform_pair_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uniform_pair_gen
//  Description : Scoreboard bench for uniform_pair_gen with a real-arithmetic
//                reference model and directed packing-boundary cases.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uniform_pair_gen;

    localparam logic [63:0] c_seed1 = 64'h0000_0000_0000_0001;
    localparam logic [63:0] c_seed2 = 64'h9E37_79B9_7F4A_7C15;
    localparam logic [63:0] c_zsub  = 64'h9E37_79B9_7F4A_7C15;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pushin = 1'b0;
    logic        seed_load = 1'b0;
    logic [63:0] seed1 = 64'd0;
    logic [63:0] seed2 = 64'd0;
    logic        pushout;
    logic [63:0] U1, U2;

    uniform_pair_gen #(
        .SEED1(c_seed1),
        .SEED2(c_seed2),
        .ZSUB (c_zsub)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pushin   (pushin),
        .seed_load(seed_load),
        .seed1    (seed1),
        .seed2    (seed2),
        .pushout  (pushout),
        .U1       (U1),
        .U2       (U2)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] u1;
        logic [63:0] u2;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    int          n_push = 0;
    int          n_pop = 0;
    logic [63:0] m1, m2;
    logic [63:0] last1 = 64'd0, last2 = 64'd0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference generator step as written in the algorithm description.
    function automatic logic [63:0] ref_step(input logic [63:0] x);
        x = x ^ (x << 13);
        x = x ^ (x >> 7);
        x = x ^ (x << 17);
        return x;
    endfunction

    // Uniform value r * 2^-53 computed in real arithmetic (exact for 53 bits).
    function automatic logic [63:0] ref_u(input logic [63:0] x);
        logic [52:0] r;
        real         v;
        r = x[63:11];
        if (r == 53'd0) r = 53'd1;
        v = real'(longint'({11'd0, r})) / (2.0 ** 53);
        return $realtobits(v);
    endfunction

    // Inverses of the xorshift sub-steps, used to pick seeds that step to a target.
    function automatic logic [63:0] un_xl(input logic [63:0] y, input int k);
        logic [63:0] x;
        x = y;
        for (int i = 0; i < 64; i++) x = y ^ (x << k);
        return x;
    endfunction

    function automatic logic [63:0] un_xr(input logic [63:0] y, input int k);
        logic [63:0] x;
        x = y;
        for (int i = 0; i < 64; i++) x = y ^ (x >> k);
        return x;
    endfunction

    function automatic logic [63:0] inv_step(input logic [63:0] y);
        return un_xl(un_xr(un_xl(y, 17), 7), 13);
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic check64(input string name, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // One cycle of stimulus; the model advances and pushes the expected pair.
    task automatic drive(input logic pi, input logic sl, input logic [63:0] s1,
                         input logic [63:0] s2, input logic ov,
                         input logic [63:0] e1, input logic [63:0] e2);
        exp_t e;
        pushin    = pi;
        seed_load = sl;
        seed1     = s1;
        seed2     = s2;
        if (sl) begin
            m1 = (s1 == 64'd0) ? c_zsub : s1;
            m2 = (s2 == 64'd0) ? c_zsub : s2;
        end else if (pi) begin
            m1    = ref_step(m1);
            m2    = ref_step(m2);
            e.u1  = ov ? e1 : ref_u(m1);
            e.u2  = ov ? e2 : ref_u(m2);
            e.due = cyc + 3;
            sb.push_back(e);
            n_push++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 64'd0, 64'd0);
    endtask

    // Monitor: pops the scoreboard on every pushout, checks timing and fields,
    // and checks that outputs hold between pushouts.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            last1 = 64'd0;
            last2 = 64'd0;
        end else if (pushout) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pushout: cyc %0d got U1=%h U2=%h expected none", cyc, U1, U2);
            end else begin
                e = sb.pop_front();
                n_pop++;
                tests++;
                if (cyc != e.due) begin
                    fails++;
                    $display("FAIL latency: pushout at cyc %0d expected cyc %0d", cyc, e.due);
                end
                check64("U1", U1, e.u1);
                check64("U2", U2, e.u2);
                tests++;
                if (U1[63] || U2[63] || U1[62:52] < 11'd970 || U1[62:52] > 11'd1022 ||
                    U2[62:52] < 11'd970 || U2[62:52] > 11'd1022) begin
                    fails++;
                    $display("FAIL fields: got U1=%h U2=%h required sign 0 exp 970..1022", U1, U2);
                end
            end
            last1 = U1;
            last2 = U2;
        end else begin
            check64("hold_U1", U1, last1);
            check64("hold_U2", U2, last2);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] tgt[4];
        logic [63:0] uexp[4];
        logic [63:0] s;
        int          issued;
        logic        pi, sl;

        m1 = c_seed1;
        m2 = c_seed2;
        repeat (3) @(posedge clk);
        #1;
        check64("reset_pushout", {63'd0, pushout}, 64'd0);
        check64("reset_U1", U1, 64'd0);
        check64("reset_U2", U2, 64'd0);
        rst = 1'b1;
        idle(2);

        // Seed both generators with 1 and request one pair.
        drive(1'b0, 1'b1, 64'd1, 64'd1, 1'b0, 64'd0, 64'd0);
        drive(1'b1, 1'b0, 64'd0, 64'd0, 1'b1, 64'h3DD0208800000000, 64'h3DD0208800000000);
        idle(5);

        // Packing boundaries and zero-r substitution via seeds chosen by inversion.
        tgt[0] = 64'h0000_0000_0000_0800; uexp[0] = 64'h3CA0000000000000;
        tgt[1] = 64'h8000_0000_0000_0000; uexp[1] = 64'h3FE0000000000000;
        tgt[2] = 64'hFFFF_FFFF_FFFF_FFFF; uexp[2] = 64'h3FEFFFFFFFFFFFFF;
        tgt[3] = 64'h0000_0000_0000_07FF; uexp[3] = 64'h3CA0000000000000;
        for (int i = 0; i < 4; i++) begin
            s = inv_step(tgt[i]);
            drive(1'b0, 1'b1, s, s, 1'b0, 64'd0, 64'd0);
            drive(1'b1, 1'b0, 64'd0, 64'd0, 1'b1, uexp[i], uexp[i]);
        end
        idle(4);

        // Zero seed substitutes ZSUB.
        drive(1'b0, 1'b1, 64'd0, rnd64(), 1'b0, 64'd0, 64'd0);
        drive(1'b1, 1'b0, 64'd0, 64'd0, 1'b0, 64'd0, 64'd0);
        // Seed load with a simultaneous request: the request is dropped.
        drive(1'b1, 1'b1, rnd64(), 64'd0, 1'b0, 64'd0, 64'd0);
        idle(5);
        drive(1'b1, 1'b0, 64'd0, 64'd0, 1'b0, 64'd0, 64'd0);
        idle(4);

        // Randomized traffic: 1000 accepted requests with gaps and reseeds.
        issued = 0;
        while (issued < 1000) begin
            pi = ($urandom_range(0, 3) != 0);
            sl = ($urandom_range(0, 39) == 0);
            drive(pi, sl, ($urandom_range(0, 3) == 0) ? 64'd0 : rnd64(),
                  ($urandom_range(0, 3) == 0) ? 64'd0 : rnd64(), 1'b0, 64'd0, 64'd0);
            if (pi && !sl) issued++;
        end
        for (int i = 0; i < 20 && sb.size() > 0; i++) idle(1);
        idle(2);
        check64("drain_empty", 64'(sb.size()), 64'd0);
        check64("push_pop_count", 64'(n_pop), 64'(n_push));

        // Asynchronous reset with one pair presented and two in flight.
        drive(1'b1, 1'b0, 64'd0, 64'd0, 1'b0, 64'd0, 64'd0);
        drive(1'b1, 1'b0, 64'd0, 64'd0, 1'b0, 64'd0, 64'd0);
        drive(1'b1, 1'b0, 64'd0, 64'd0, 1'b0, 64'd0, 64'd0);
        pushin = 1'b0;
        rst    = 1'b0;
        sb.delete();
        #1;
        check64("async_rst_pushout", {63'd0, pushout}, 64'd0);
        check64("async_rst_U1", U1, 64'd0);
        check64("async_rst_U2", U2, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        m1  = c_seed1;
        m2  = c_seed2;
        drive(1'b1, 1'b0, 64'd0, 64'd0, 1'b0, 64'd0, 64'd0);
        for (int i = 0; i < 10 && sb.size() > 0; i++) idle(1);
        idle(2);
        check64("post_reset_drain", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
